// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller for a 5-stage in-order core.
// Decides, every cycle, which pipeline registers load, which get cleared to
// NOP, and tracks halt draining plus a saturating stall counter.
//
// Ports:
//   clk, reset            - clock; asynchronous active-low reset
//   id_rs1/id_rs2         - source registers of the instruction in IF/ID
//   id_use_rs1/id_use_rs2 - the ID instruction really reads that source
//   ex_rd, ex_memread     - destination and MemRead of the instruction in ID/EX
//   ex_branch_taken       - branch/jalr resolved taken in EX
//   ex_halt               - halt instruction reached EX
//   mem_req, mem_ack      - data memory access active / completing this cycle
//   pc_en .. mem_wb_en    - pipeline register load enables
//   if_id_flush, id_ex_flush, mem_wb_bubble - clear-to-NOP on next edge
//   halted                - processor stopped
//   stall_cnt             - saturating count of cycles with pc_en low
module pipe_flow_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    input  logic             ex_halt,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        DRAIN,
        HALTED
    } state_t;

    // Drain counter counts DRAIN_CYCLES-1 down to 0 (DRAIN_CYCLES >= 1).
    localparam int unsigned DCW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

    state_t           state_q, state_d;
    logic [DCW-1:0]   drain_q, drain_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             halted_q, halted_d;

    logic mem_stall;
    logic load_use;

    assign mem_stall = mem_req & ~mem_ack;

    // x0 never creates a hazard; only sources the ID instruction reads count.
    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;

        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    id_ex_en      = 1'b0;
                    ex_mem_en     = 1'b0;
                    mem_wb_bubble = 1'b1;
                    state_d       = MEM_WAIT;
                end else if (ex_halt) begin
                    pc_en       = 1'b0;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    drain_d     = DRAIN_LOAD;
                    state_d     = DRAIN;
                end else if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end

            MEM_WAIT: begin
                pc_en    = 1'b0;
                if_id_en = 1'b0;
                id_ex_en = 1'b0;
                if (mem_ack) begin
                    state_d = RUN;
                end else begin
                    ex_mem_en     = 1'b0;
                    mem_wb_bubble = 1'b1;
                end
            end

            DRAIN: begin
                if (mem_stall) begin
                    // Counter holds so the stall lengthens the drain.
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    id_ex_en      = 1'b0;
                    ex_mem_en     = 1'b0;
                    mem_wb_bubble = 1'b1;
                end else begin
                    pc_en       = 1'b0;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (drain_q == '0) begin
                        state_d = HALTED;
                    end else begin
                        drain_d = drain_q - DCW'(1);
                    end
                end
            end

            HALTED: begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
                mem_wb_en = 1'b0;
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Only front-end stalls while running count; drain/halt cycles do not.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && ((state_q == RUN) || (state_q == MEM_WAIT)) &&
            (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            drain_q     <= '0;
            stall_cnt_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            stall_cnt_q <= stall_cnt_d;
            halted_q    <= halted_d;
        end
    end

    assign halted    = halted_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Self-checking bench for pipe_flow_ctrl. Expected outputs are pushed to a
// scoreboard queue when stimulus is applied and compared after sampling.
module tb_pipe_flow_ctrl;

    localparam int unsigned CW = 4;

    // Output vector order: pc, if_id, id_ex, ex_mem, mem_wb enables,
    // if_id_flush, id_ex_flush, mem_wb_bubble, halted.
    localparam logic [8:0] DEF_O    = 9'b1_1_1_1_1_0_0_0_0;
    localparam logic [8:0] LU_O     = 9'b0_0_1_1_1_0_1_0_0;
    localparam logic [8:0] BR_O     = 9'b1_1_1_1_1_1_1_0_0;
    localparam logic [8:0] MSTALL_O = 9'b0_0_0_0_1_0_0_1_0;
    localparam logic [8:0] MACK_O   = 9'b0_0_0_1_1_0_0_0_0;
    localparam logic [8:0] HALT_O   = 9'b0_1_1_1_1_1_1_0_0;
    localparam logic [8:0] DRAIN_O  = 9'b0_1_1_1_1_1_1_0_0;
    localparam logic [8:0] HALTED_O = 9'b0_0_0_0_0_0_0_0_1;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       ht;
        logic       mreq;
        logic       mack;
    } stim_t;

    typedef struct packed {
        logic [8:0]    o;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk;
    logic          reset;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2;
    logic          ex_memread, ex_branch_taken, ex_halt, mem_req, mem_ack;
    logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic          if_id_flush, id_ex_flush, mem_wb_bubble, halted;
    logic [CW-1:0] stall_cnt;
    logic [8:0]    dut_o;

    int unsigned   checks;
    int unsigned   errors;
    logic [CW-1:0] exp_cnt;
    exp_t          sb[$];
    exp_t          obs[$];

    pipe_flow_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread),
        .ex_branch_taken(ex_branch_taken), .ex_halt(ex_halt),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_bubble(mem_wb_bubble), .halted(halted),
        .stall_cnt(stall_cnt)
    );

    assign dut_o = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                    if_id_flush, id_ex_flush, mem_wb_bubble, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t st(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2,
                                 input logic [4:0] rd, input logic mr,
                                 input logic br, input logic ht,
                                 input logic mreq, input logic mack);
        stim_t s;
        s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.rd = rd;
        s.mr = mr; s.br = br; s.ht = ht; s.mreq = mreq; s.mack = mack;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        id_rs1 = s.rs1; id_rs2 = s.rs2; id_use_rs1 = s.u1; id_use_rs2 = s.u2;
        ex_rd = s.rd; ex_memread = s.mr; ex_branch_taken = s.br;
        ex_halt = s.ht; mem_req = s.mreq; mem_ack = s.mack;
    endtask

    // One cycle: drive, record expectation, sample, advance the count model.
    task automatic apply(input stim_t s, input logic [8:0] o, input logic inc);
        exp_t e;
        exp_t a;
        @(negedge clk);
        drive(s);
        e.o = o;
        e.cnt = exp_cnt;
        sb.push_back(e);
        #1;
        a.o = dut_o;
        a.cnt = stall_cnt;
        obs.push_back(a);
        @(posedge clk);
        if (inc && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    endtask

    task automatic test_reset(input string tag);
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2 reset = 1'b0;
        #1;
        checks++;
        if (dut_o !== DEF_O) begin
            errors++;
            $display("FAIL reset_%s outs got %b want %b", tag, dut_o, DEF_O);
        end
        checks++;
        if (stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_%s stall_cnt got %0d want 0", tag, stall_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_cnt = '0;
    endtask

    task automatic test_load_use();
        exp_t e, a;
        int unsigned i;
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), DEF_O, 1'b0);
        apply(st(0, 5, 0, 1, 5, 1, 0, 0, 0, 0), LU_O, 1'b1);
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), DEF_O, 1'b0);
        apply(st(7, 0, 1, 0, 7, 1, 0, 0, 0, 0), LU_O, 1'b1);
        apply(st(0, 0, 1, 1, 0, 1, 0, 0, 0, 0), DEF_O, 1'b0);
        apply(st(5, 0, 0, 0, 5, 1, 0, 0, 0, 0), DEF_O, 1'b0);
        apply(st(5, 5, 1, 1, 5, 0, 0, 0, 0, 0), DEF_O, 1'b0);
        apply(st(3, 9, 1, 1, 9, 1, 0, 0, 0, 0), LU_O, 1'b1);
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), DEF_O, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = obs.pop_front();
            checks++;
            if (a.o !== e.o) begin
                errors++;
                $display("FAIL load_use[%0d] outs got %b want %b", i, a.o, e.o);
            end
            checks++;
            if (a.cnt !== e.cnt) begin
                errors++;
                $display("FAIL load_use[%0d] stall_cnt got %0d want %0d", i, a.cnt, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_branch();
        exp_t e, a;
        int unsigned i;
        apply(st(0, 5, 0, 1, 5, 1, 1, 0, 0, 0), BR_O, 1'b0);
        apply(st(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), BR_O, 1'b0);
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), DEF_O, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = obs.pop_front();
            checks++;
            if (a.o !== e.o) begin
                errors++;
                $display("FAIL branch[%0d] outs got %b want %b", i, a.o, e.o);
            end
            checks++;
            if (a.cnt !== e.cnt) begin
                errors++;
                $display("FAIL branch[%0d] stall_cnt got %0d want %0d", i, a.cnt, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_mem_wait();
        exp_t e, a;
        int unsigned i;
        for (int k = 0; k < 3; k++)
            apply(st(0, 0, 0, 0, 0, 0, 1, 0, 1, 0), MSTALL_O, 1'b1);
        apply(st(0, 0, 0, 0, 0, 0, 1, 0, 1, 1), MACK_O, 1'b1);
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), DEF_O, 1'b0);
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), DEF_O, 1'b0);
        apply(st(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), MSTALL_O, 1'b1);
        apply(st(0, 0, 0, 0, 0, 0, 0, 1, 1, 1), MACK_O, 1'b1);
        apply(st(0, 5, 0, 1, 5, 1, 0, 0, 1, 0), MSTALL_O, 1'b1);
        apply(st(0, 5, 0, 1, 5, 1, 0, 0, 1, 1), MACK_O, 1'b1);
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), DEF_O, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = obs.pop_front();
            checks++;
            if (a.o !== e.o) begin
                errors++;
                $display("FAIL mem_wait[%0d] outs got %b want %b", i, a.o, e.o);
            end
            checks++;
            if (a.cnt !== e.cnt) begin
                errors++;
                $display("FAIL mem_wait[%0d] stall_cnt got %0d want %0d", i, a.cnt, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_saturate();
        exp_t e, a;
        int unsigned i;
        for (int k = 0; k < 20; k++)
            apply(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), MSTALL_O, 1'b1);
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), MACK_O, 1'b1);
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), DEF_O, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = obs.pop_front();
            checks++;
            if (a.o !== e.o) begin
                errors++;
                $display("FAIL saturate[%0d] outs got %b want %b", i, a.o, e.o);
            end
            checks++;
            if (a.cnt !== e.cnt) begin
                errors++;
                $display("FAIL saturate[%0d] stall_cnt got %0d want %0d", i, a.cnt, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_halt_drain();
        exp_t e, a;
        int unsigned i;
        apply(st(0, 0, 0, 0, 0, 0, 1, 1, 0, 0), HALT_O, 1'b1);
        for (int k = 0; k < 3; k++)
            apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), DRAIN_O, 1'b0);
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), HALTED_O, 1'b0);
        apply(st(0, 5, 0, 1, 5, 1, 1, 1, 1, 0), HALTED_O, 1'b0);
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), HALTED_O, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = obs.pop_front();
            checks++;
            if (a.o !== e.o) begin
                errors++;
                $display("FAIL halt_drain[%0d] outs got %b want %b", i, a.o, e.o);
            end
            checks++;
            if (a.cnt !== e.cnt) begin
                errors++;
                $display("FAIL halt_drain[%0d] stall_cnt got %0d want %0d", i, a.cnt, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_drain_stall();
        exp_t e, a;
        int unsigned i;
        apply(st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), HALT_O, 1'b1);
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), DRAIN_O, 1'b0);
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), MSTALL_O, 1'b0);
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), MSTALL_O, 1'b0);
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), DRAIN_O, 1'b0);
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), DRAIN_O, 1'b0);
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), HALTED_O, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = obs.pop_front();
            checks++;
            if (a.o !== e.o) begin
                errors++;
                $display("FAIL drain_stall[%0d] outs got %b want %b", i, a.o, e.o);
            end
            checks++;
            if (a.cnt !== e.cnt) begin
                errors++;
                $display("FAIL drain_stall[%0d] stall_cnt got %0d want %0d", i, a.cnt, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_reset_abort();
        exp_t e, a;
        int unsigned i;
        apply(st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), HALT_O, 1'b1);
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), DRAIN_O, 1'b0);
        test_reset("mid_drain");
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), DEF_O, 1'b0);
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), MSTALL_O, 1'b1);
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), MSTALL_O, 1'b1);
        test_reset("mid_mem_wait");
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), DEF_O, 1'b0);
        apply(st(0, 5, 0, 1, 5, 1, 0, 0, 0, 0), LU_O, 1'b1);
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), DEF_O, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = obs.pop_front();
            checks++;
            if (a.o !== e.o) begin
                errors++;
                $display("FAIL reset_abort[%0d] outs got %b want %b", i, a.o, e.o);
            end
            checks++;
            if (a.cnt !== e.cnt) begin
                errors++;
                $display("FAIL reset_abort[%0d] stall_cnt got %0d want %0d", i, a.cnt, e.cnt);
            end
            i++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = '0;
        reset   = 1'b0;
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        @(posedge clk);
        test_reset("initial");
        test_load_use();
        test_branch();
        test_mem_wait();
        test_saturate();
        test_reset("after_saturate");
        test_halt_drain();
        test_reset("after_halted");
        test_drain_stall();
        test_reset("after_drain_stall");
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
